ctrl_pipe: RTL and testbench

- Pipelined successor to the combinational control decoder.
- Decodes one instruction per cycle into a registered decode/execute control word, with valid/ready handshakes on both sides.
- Adds a one-bubble load-use hazard stall, jump-shadow squashing and saturating performance counters.
- Sits between instruction fetch and the execute stage; widths and shadow depth are parametrised.

---
 rtl/ctrl_pipe.sv | 155 +++++++++++++++
 tb/tb_ctrl_pipe.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: registered instruction decoder with load-use stall,
// jump-shadow squashing and saturating performance counters.
module ctrl_pipe #(
    parameter int IW          = 9,
    parameter int OPW         = 3,
    parameter int RAW         = 3,
    parameter int JUMP_SHADOW = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IW-1:0]    mach_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             regWrite,
    output logic             memRead,
    output logic             memWrite,
    output logic             aluSrc,
    output logic             branch,
    output logic             jump,
    output logic [OPW-1:0]   alu_op,
    output logic [RAW-1:0]   ra,
    output logic [RAW-1:0]   rb,
    output logic             flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] squash_cnt
);

    typedef struct packed {
        logic           valid;
        logic           rw;
        logic           mr;
        logic           mw;
        logic           as;
        logic           jmp;
        logic [OPW-1:0] op;
        logic [RAW-1:0] ra;
        logic [RAW-1:0] rb;
    } word_t;

    word_t            word_q, word_d, dec;
    logic             flush_q, flush_d;
    logic [2:0]       shadow_q, shadow_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] squash_q, squash_d;

    logic [OPW-1:0] opc;
    logic [RAW-1:0] fa, fb;
    logic           use_a, use_b;
    logic           hazard, advance, accept;

    assign opc = mach_code[IW-1 -: OPW];
    assign fa  = mach_code[IW-OPW-1 -: RAW];
    assign fb  = mach_code[IW-OPW-RAW-1 -: RAW];

    always_comb begin
        dec       = '0;
        use_a     = 1'b0;
        use_b     = 1'b0;
        dec.valid = 1'b1;
        dec.op    = opc;
        dec.ra    = fa;
        dec.rb    = fb;
        case (opc)
            OPW'(0): begin dec.rw = 1'b1; use_a = 1'b1; use_b = 1'b1; end
            OPW'(1): begin dec.rw = 1'b1; dec.as = 1'b1; use_a = 1'b1; end
            OPW'(2): begin dec.rw = 1'b1; use_a = 1'b1; use_b = 1'b1; end
            OPW'(3): begin
                dec.rw = 1'b1;
                dec.mr = 1'b1;
                dec.as = 1'b1;
                use_b  = 1'b1;
            end
            OPW'(4): begin
                dec.mw = 1'b1;
                dec.as = 1'b1;
                use_a  = 1'b1;
                use_b  = 1'b1;
            end
            OPW'(5): dec.jmp = 1'b1;
            OPW'(6): begin dec.rw = 1'b1; use_a = 1'b1; use_b = 1'b1; end
            OPW'(7): begin dec.rw = 1'b1; use_a = 1'b1; end
            default: ;
        endcase
    end

    // A load at the output blocks any consumer of its destination for one cycle.
    assign hazard = word_q.valid && word_q.mr && in_valid &&
                    ((use_a && (fa == word_q.ra)) ||
                     (use_b && (fb == word_q.ra)));
    assign advance  = !word_q.valid || out_ready;
    assign in_ready = advance && !hazard;
    assign accept   = in_valid && in_ready;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    always_comb begin
        word_d   = word_q;
        flush_d  = 1'b0;
        shadow_d = shadow_q;
        stall_d  = stall_q;
        squash_d = squash_q;
        if (advance) begin
            word_d = '0;
            if (hazard) begin
                stall_d = sat_inc(stall_q);
            end else if (accept) begin
                if (shadow_q != 3'd0) begin
                    shadow_d = shadow_q - 3'd1;
                    squash_d = sat_inc(squash_q);
                end else begin
                    word_d  = dec;
                    flush_d = dec.jmp;
                    if (dec.jmp)
                        shadow_d = 3'(JUMP_SHADOW);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q   <= '0;
            flush_q  <= 1'b0;
            shadow_q <= 3'd0;
            stall_q  <= '0;
            squash_q <= '0;
        end else begin
            word_q   <= word_d;
            flush_q  <= flush_d;
            shadow_q <= shadow_d;
            stall_q  <= stall_d;
            squash_q <= squash_d;
        end
    end

    assign out_valid  = word_q.valid;
    assign regWrite   = word_q.rw;
    assign memRead    = word_q.mr;
    assign memWrite   = word_q.mw;
    assign aluSrc     = word_q.as;
    assign branch     = 1'b0;
    assign jump       = word_q.jmp;
    assign alu_op     = word_q.op;
    assign ra         = word_q.ra;
    assign rb         = word_q.rb;
    assign flush      = flush_q;
    assign stall_cnt  = stall_q;
    assign squash_cnt = squash_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed scoreboard bench for ctrl_pipe
// (CNT_W=2 so counter saturation is reachable).
module tb_ctrl_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] mach_code;
    logic       out_valid;
    logic       out_ready;
    logic       regWrite, memRead, memWrite, aluSrc, branch, jump;
    logic [2:0] alu_op, ra, rb;
    logic       flush;
    logic [1:0] stall_cnt, squash_cnt;

    int n_chk = 0;
    int n_err = 0;
    logic [14:0] sb_q[$];
    logic [14:0] last_w = '0;

    ctrl_pipe #(
        .IW(9), .OPW(3), .RAW(3), .JUMP_SHADOW(1), .CNT_W(2)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .mach_code(mach_code),
        .out_valid(out_valid), .out_ready(out_ready),
        .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite),
        .aluSrc(aluSrc), .branch(branch), .jump(jump),
        .alu_op(alu_op), .ra(ra), .rb(rb),
        .flush(flush),
        .stall_cnt(stall_cnt), .squash_cnt(squash_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] mk(input int op, input int a, input int b);
        logic [2:0] o, x, y;
        o = 3'(op);
        x = 3'(a);
        y = 3'(b);
        return {o, x, y};
    endfunction

    function automatic logic [14:0] ref_word(input logic [8:0] c);
        logic [2:0] op;
        logic rw, mr, mw, as, j;
        op = c[8:6];
        rw = (op != 3'd4) && (op != 3'd5);
        mr = (op == 3'd3);
        mw = (op == 3'd4);
        as = (op == 3'd1) || (op == 3'd3) || (op == 3'd4);
        j  = (op == 3'd5);
        return {rw, mr, mw, as, 1'b0, j, op, c[5:3], c[2:0]};
    endfunction

    function automatic logic [14:0] dut_word();
        return {regWrite, memRead, memWrite, aluSrc, branch, jump,
                alu_op, ra, rb};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, check in_ready, clock, check the output side.
    task automatic step(input logic v, input logic [8:0] c, input logic r,
                        input logic exp_rdy, input logic push,
                        input logic new_w, input logic exp_ov,
                        input logic exp_fl);
        in_valid  = v;
        mach_code = c;
        out_ready = r;
        #1;
        chk("in_ready", in_ready, exp_rdy);
        if (push)
            sb_q.push_back(ref_word(c));
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, exp_ov);
        chk("flush", flush, exp_fl);
        if (new_w) begin
            chk("sb_nonempty", sb_q.size() != 0, 1);
            if (sb_q.size() != 0)
                last_w = sb_q.pop_front();
            chk("word", dut_word(), last_w);
        end else if (exp_ov) begin
            chk("held_word", dut_word(), last_w);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b1;
        mach_code = mk(0, 1, 2);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_word", dut_word(), 0);
        chk("rst_flush", flush, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_squash", squash_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        reset = 1'b0;

        // streaming: AND, ADDI, XOR, STORE
        step(1, mk(0, 1, 2), 1, 1, 1, 1, 1, 0);
        step(1, mk(1, 3, 4), 1, 1, 1, 1, 1, 0);
        chk("addi_rw_as", {regWrite, aluSrc}, 2'b11);
        step(1, mk(2, 5, 6), 1, 1, 1, 1, 1, 0);
        step(1, mk(4, 7, 1), 1, 1, 1, 1, 1, 0);
        chk("store_ctl", {memWrite, aluSrc, regWrite}, 3'b110);
        step(0, mk(0, 0, 0), 1, 1, 0, 0, 0, 0);

        // load-use: LOAD r2 then AND r2,r5 stalls once
        step(1, mk(3, 2, 1), 1, 1, 1, 1, 1, 0);
        step(1, mk(0, 2, 5), 1, 0, 0, 0, 0, 0);
        chk("stall_1", stall_cnt, 1);
        step(1, mk(0, 2, 5), 1, 1, 1, 1, 1, 0);
        // LOAD r2 then ADDI r3 (rb=2 is not a source): no stall
        step(1, mk(3, 2, 1), 1, 1, 1, 1, 1, 0);
        step(1, mk(1, 3, 2), 1, 1, 1, 1, 1, 0);
        chk("stall_still_1", stall_cnt, 1);
        step(0, mk(0, 0, 0), 1, 1, 0, 0, 0, 0);

        // jump squash: JUMP, SUB (squashed), SHF
        step(1, mk(5, 0, 0), 1, 1, 1, 1, 1, 1);
        chk("jump_bit", jump, 1);
        step(1, mk(6, 1, 1), 1, 1, 0, 0, 0, 0);
        step(1, mk(7, 2, 3), 1, 1, 1, 1, 1, 0);
        chk("squash_1", squash_cnt, 1);
        step(0, mk(0, 0, 0), 1, 1, 0, 0, 0, 0);

        // backpressure on a jump
        step(1, mk(5, 4, 4), 1, 1, 1, 1, 1, 1);
        for (int i = 0; i < 3; i++)
            step(1, mk(6, 1, 1), 0, 0, 0, 0, 1, 0);
        chk("bp_squash", squash_cnt, 1);
        step(1, mk(6, 1, 1), 1, 1, 0, 0, 0, 0);
        chk("squash_2", squash_cnt, 2);
        step(1, mk(7, 5, 0), 1, 1, 1, 1, 1, 0);

        // reset mid-operation clears the word, shadow and counters
        step(1, mk(5, 0, 0), 1, 1, 1, 1, 1, 1);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_stall", stall_cnt, 0);
        chk("mid_rst_squash", squash_cnt, 0);
        step(1, mk(6, 1, 2), 1, 1, 1, 1, 1, 0);

        // saturation: five load-use pairs with a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            step(1, mk(3, i + 1, 0), 1, 1, 1, 1, 1, 0);
            step(1, mk(0, i + 1, 6), 1, 0, 0, 0, 0, 0);
            step(1, mk(0, i + 1, 6), 1, 1, 1, 1, 1, 0);
            chk("stall_sat", stall_cnt, (i + 1 > 3) ? 3 : i + 1);
        end
        step(0, mk(0, 0, 0), 1, 1, 0, 0, 0, 0);
        chk("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
